// File: rtl/compl_div.sv
// compl_div: complex quotient N*conj(D)/|D|^2 using a 19-cycle restoring divider per part.
module compl_div (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic signed [36:0] data_n_i_i,
  input  logic signed [36:0] data_n_q_i,
  input  logic signed [17:0] data_d_i_i,
  input  logic signed [17:0] data_d_q_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic signed [17:0] data_i_o,
  output logic signed [17:0] data_q_o,
  output logic               div_zero_o,
  output logic               sat_o
);
  typedef enum logic [1:0] {IDLE, PROD, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic signed [36:0] ni_q, ni_d, nq_q, nq_d;
  logic signed [17:0] di_q, di_d, dq_q, dq_d, oi_q, oi_d, oq_q, oq_d;
  logic [55:0] ri_q, ri_d, rq_q, rq_d;
  logic [35:0] den_q, den_d;
  logic [17:0] qi_q, qi_d, qq_q, qq_d;
  logic [4:0] cnt_q, cnt_d;
  logic si_q, si_d, sq_q, sq_d, ovi_q, ovi_d, ovq_q, ovq_d, dz_q, dz_d, sat_q, sat_d;
  logic signed [55:0] pi, pq;
  logic [55:0] mi, mq, lim, ti, tq;
  logic [35:0] den;
  logic bi, bq;
  logic [18:0] fi, fq;
  // {saturated, signed value} from the magnitude quotient and the sign of P
  function automatic logic [18:0] fin(input logic neg, input logic ovf, input logic [18:0] m);
    logic s;
    s = ovf | (m > (neg ? 19'd131072 : 19'd131071));
    return s ? {1'b1, neg ? 18'h20000 : 18'h1ffff} : {1'b0, neg ? ~m[17:0] + 18'd1 : m[17:0]};
  endfunction
  assign pi  = 56'(ni_q) * 56'(di_q) + 56'(nq_q) * 56'(dq_q);
  assign pq  = 56'(nq_q) * 56'(di_q) - 56'(ni_q) * 56'(dq_q);
  assign den = 36'(di_q) * 36'(di_q) + 36'(dq_q) * 36'(dq_q);
  assign mi  = pi[55] ? -pi : pi;
  assign mq  = pq[55] ? -pq : pq;
  assign lim = {1'b0, den, 19'd0};
  assign ti  = {20'd0, den_q} << cnt_q;
  assign tq  = ti;
  assign bi  = ri_q >= ti;
  assign bq  = rq_q >= tq;
  assign fi  = fin(si_q, ovi_q, {qi_q, bi});
  assign fq  = fin(sq_q, ovq_q, {qq_q, bq});
  always_comb begin
    state_d = state_q;
    ni_d = ni_q; nq_d = nq_q; di_d = di_q; dq_d = dq_q;
    ri_d = ri_q; rq_d = rq_q; den_d = den_q; qi_d = qi_q; qq_d = qq_q;
    cnt_d = cnt_q; si_d = si_q; sq_d = sq_q; ovi_d = ovi_q; ovq_d = ovq_q;
    oi_d = oi_q; oq_d = oq_q; dz_d = dz_q; sat_d = sat_q;
    unique case (state_q)
      IDLE: if (valid_i) begin
        ni_d = data_n_i_i; nq_d = data_n_q_i; di_d = data_d_i_i; dq_d = data_d_q_i;
        state_d = PROD;
      end
      PROD: if (den == '0) begin
        state_d = DONE; oi_d = '0; oq_d = '0; dz_d = 1'b1; sat_d = 1'b0;
      end else begin
        state_d = DIV; cnt_d = 5'd18; den_d = den;
        ri_d = mi; rq_d = mq; si_d = pi[55]; sq_d = pq[55];
        ovi_d = mi >= lim; ovq_d = mq >= lim; qi_d = '0; qq_d = '0;
      end
      DIV: begin
        ri_d = bi ? ri_q - ti : ri_q;
        rq_d = bq ? rq_q - tq : rq_q;
        qi_d = {qi_q[16:0], bi};
        qq_d = {qq_q[16:0], bq};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = DONE; cnt_d = '0;
          oi_d = fi[17:0]; oq_d = fq[17:0]; sat_d = fi[18] | fq[18]; dz_d = 1'b0;
        end
      end
      DONE: if (ready_i) begin
        state_d = IDLE; oi_d = '0; oq_d = '0; dz_d = 1'b0; sat_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      ni_q <= '0; nq_q <= '0; di_q <= '0; dq_q <= '0;
      ri_q <= '0; rq_q <= '0; den_q <= '0; qi_q <= '0; qq_q <= '0;
      cnt_q <= '0; si_q <= 1'b0; sq_q <= 1'b0; ovi_q <= 1'b0; ovq_q <= 1'b0;
      oi_q <= '0; oq_q <= '0; dz_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ni_q <= ni_d; nq_q <= nq_d; di_q <= di_d; dq_q <= dq_d;
      ri_q <= ri_d; rq_q <= rq_d; den_q <= den_d; qi_q <= qi_d; qq_q <= qq_d;
      cnt_q <= cnt_d; si_q <= si_d; sq_q <= sq_d; ovi_q <= ovi_d; ovq_q <= ovq_d;
      oi_q <= oi_d; oq_q <= oq_d; dz_q <= dz_d; sat_q <= sat_d;
    end
  end
  assign ready_o    = state_q == IDLE;
  assign valid_o    = state_q == DONE;
  assign data_i_o   = oi_q;
  assign data_q_o   = oq_q;
  assign div_zero_o = dz_q;
  assign sat_o      = sat_q;
endmodule

// File: tb/tb_compl_div.sv
// tb_compl_div: scoreboard bench for compl_div against an integer-division reference model.
module tb_compl_div;
  logic clk = 1'b0, arst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
  logic ready_o, valid_o, div_zero_o, sat_o;
  logic signed [36:0] data_n_i_i = '0, data_n_q_i = '0;
  logic signed [17:0] data_d_i_i = '0, data_d_q_i = '0;
  logic signed [17:0] data_i_o, data_q_o;
  typedef struct { logic signed [17:0] ei, eq; logic dz, sat; int acc; } exp_t;
  exp_t sb[$];
  exp_t h;
  int checks = 0, errors = 0, cyc = 0, last_cons = -10;
  bit rand_rdy = 0, was_v = 0;
  logic signed [17:0] hi, hq;
  logic hdz, hsat;
  compl_div dut (
    .clk_i(clk), .arst_i(arst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_n_i_i(data_n_i_i), .data_n_q_i(data_n_q_i),
    .data_d_i_i(data_d_i_i), .data_d_q_i(data_d_q_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_i_o(data_i_o), .data_q_o(data_q_o),
    .div_zero_o(div_zero_o), .sat_o(sat_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic longint clip(input longint v);
    return v > 131071 ? 131071 : (v < -131072 ? -131072 : v);
  endfunction
  function automatic exp_t model(input longint ni, input longint nq, input longint di, input longint dq);
    exp_t e;
    longint pi, pq, den, qi, qq;
    pi = ni * di + nq * dq;
    pq = nq * di - ni * dq;
    den = di * di + dq * dq;
    e.dz = den == 0; e.sat = 1'b0; e.ei = '0; e.eq = '0; e.acc = 0;
    if (den != 0) begin
      qi = pi / den;
      qq = pq / den;
      e.sat = clip(qi) != qi || clip(qq) != qq;
      e.ei = 18'(clip(qi));
      e.eq = 18'(clip(qq));
    end
    return e;
  endfunction
  task automatic send(input logic signed [36:0] ni, input logic signed [36:0] nq,
                      input logic signed [17:0] di, input logic signed [17:0] dq);
    exp_t e;
    int n = 0;
    @(negedge clk);
    data_n_i_i = ni; data_n_q_i = nq; data_d_i_i = di; data_d_q_i = dq; valid_i = 1'b1;
    while (!ready_o && n < 300) begin @(negedge clk); n++; end
    chk("accept_ready", ready_o, 1);
    if (ready_o) begin
      e = model(ni, nq, di, dq);
      e.acc = cyc + 1;
      chk("accept_after_consume", e.acc > last_cons, 1);
      sb.push_back(e);
      @(posedge clk);
    end
    #1 valid_i = 1'b0;
  endtask
  task automatic wait_valid;
    int n = 0;
    while (!valid_o && n < 100) begin @(negedge clk); n++; end
    chk("wait_valid", valid_o, 1);
  endtask
  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
  endtask
  task automatic pulse_reset;
    @(posedge clk);
    #3 arst_i = 1'b1;
    #1;
    chk("rst_data_i", data_i_o, 0); chk("rst_data_q", data_q_o, 0);
    chk("rst_div_zero", div_zero_o, 0); chk("rst_sat", sat_o, 0);
    chk("rst_ready", ready_o, 1); chk("rst_valid", valid_o, 0);
    sb.delete();
    was_v = 0;
    #4 arst_i = 1'b0;
  endtask
  task automatic rand_send;
    logic signed [17:0] di, dq, xi, xq;
    logic signed [36:0] ni, nq;
    int m = $urandom_range(0, 7);
    di = 18'($urandom); dq = 18'($urandom);
    if (m == 0) begin di = '0; dq = '0; end
    else if (m == 1) begin di = 18'($urandom_range(0, 16)) - 18'sd8; dq = 18'($urandom_range(0, 16)) - 18'sd8; end
    if (m <= 2) begin
      ni = 37'({$urandom, $urandom}); nq = 37'({$urandom, $urandom});
    end else begin
      xi = 18'($urandom); xq = 18'($urandom);
      ni = 37'(xi) * 37'(di) - 37'(xq) * 37'(dq) + 37'($signed(4'($urandom)));
      nq = 37'(xq) * 37'(di) + 37'(xi) * 37'(dq) + 37'($signed(4'($urandom)));
    end
    send(ni, nq, di, dq);
  endtask
  always @(negedge clk) begin
    if (!arst_i) begin
      if (valid_o) begin
        if (!was_v) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            h = sb[0];
            chk("latency", cyc - h.acc, h.dz ? 1 : 20);
            chk("data_i", data_i_o, h.ei); chk("data_q", data_q_o, h.eq);
            chk("div_zero", div_zero_o, h.dz); chk("sat", sat_o, h.sat);
          end
          hi = data_i_o; hq = data_q_o; hdz = div_zero_o; hsat = sat_o;
        end else begin
          chk("hold_data_i", data_i_o, hi); chk("hold_data_q", data_q_o, hq);
          chk("hold_flags", {div_zero_o, sat_o}, {hdz, hsat});
        end
        chk("ready_while_valid", ready_o, 0);
        if (ready_i) begin
          if (sb.size() != 0) void'(sb.pop_front());
          last_cons = cyc + 1;
        end
        was_v = !ready_i;
      end else begin
        chk("idle_flags", {div_zero_o, sat_o}, 0);
        was_v = 0;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #2 if (rand_rdy) ready_i = ($urandom % 3) != 0;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    #1;
    chk("init_ready", ready_o, 1); chk("init_valid", valid_o, 0);
    chk("init_data_i", data_i_o, 0); chk("init_data_q", data_q_o, 0);
    chk("init_div_zero", div_zero_o, 0); chk("init_sat", sat_o, 0);
    #22 arst_i = 1'b0;
    ready_i = 1'b1;
    send(-37'sd5, 37'sd10, 18'sd1, 18'sd2);
    send(37'sd7, -37'sd7, 18'sd2, 18'sd0);
    send(37'sd1000000000, -37'sd1000000000, 18'sd1, 18'sd0);
    send(37'sd5, 37'sd5, 18'sd0, 18'sd0);
    send(37'sd131071, -37'sd131072, 18'sd1, 18'sd0);
    send(37'sd131072, -37'sd131073, 18'sd1, 18'sd0);
    send(37'sh10_0000_0000, 37'sh0f_ffff_ffff, 18'sh20000, 18'sh20000);
    send(37'sd0, -37'sd3, 18'sd5, -18'sd7);
    drain();
    @(posedge clk); #2 ready_i = 1'b0;
    send(37'sd100, -37'sd50, 18'sd3, 18'sd4);
    fork
      send(-37'sd9, 37'sd21, 18'sd2, -18'sd1);
      begin
        wait_valid();
        repeat (10) @(posedge clk);
        #2 ready_i = 1'b1;
      end
    join
    drain();
    send(37'sd123456789, -37'sd98765, 18'sd300, -18'sd77);
    repeat (8) @(posedge clk);
    pulse_reset();
    repeat (30) @(posedge clk);
    #2 ready_i = 1'b0;
    send(-37'sd5, 37'sd10, 18'sd1, 18'sd2);
    wait_valid();
    pulse_reset();
    repeat (5) @(posedge clk);
    #2 ready_i = 1'b1;
    send(37'sd7, -37'sd7, 18'sd2, 18'sd0);
    drain();
    rand_rdy = 1;
    repeat (150) rand_send();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
